// File: rtl/wrs_pkg.sv
// rtl/wrs_pkg.sv - shared constants, state encoding and helpers for weighted_random_select
package wrs_pkg;

    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAW    = 2'd1,
        ST_PRESENT = 2'd2
    } wrs_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            16:      return {16'h0, LFSR_TAPS_16};
            24:      return {8'h0, LFSR_TAPS_24};
            default: return LFSR_TAPS_32;
        endcase
    endfunction

endpackage

// File: rtl/wrs_lfsr.sv
// rtl/wrs_lfsr.sv - right-shifting Galois LFSR with seed load and zero-seed guard
module wrs_lfsr
    import wrs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_seed_load,
    input  logic [WIDTH-1:0] in_seed,
    input  logic             in_step,
    output logic [WIDTH-1:0] out_state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    // The all-zero state is a lock-up point, so a zero seed is mapped to 1.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            out_state <= WIDTH'(1);
        end else if (in_seed_load) begin
            out_state <= (in_seed == '0) ? WIDTH'(1) : in_seed;
        end else if (in_step) begin
            out_state <= out_state[0] ? ((out_state >> 1) ^ TAPS) : (out_state >> 1);
        end
    end

endmodule

// File: rtl/weighted_random_select.sv
// rtl/weighted_random_select.sv - weighted segment picker using LFSR rejection sampling
module weighted_random_select
    import wrs_pkg::*;
#(
    parameter  int NUM_SEG   = 4,
    parameter  int WEIGHT_W  = 8,
    parameter  int LFSR_W    = 32,
    parameter  int MAX_RETRY = 8,
    localparam int SEG_W     = (clog2(NUM_SEG) > 1) ? clog2(NUM_SEG) : 1,
    localparam int TOT_W     = WEIGHT_W + clog2(NUM_SEG),
    localparam int CNT_W     = clog2(MAX_RETRY + 1) + 1
) (
    input  logic                        in_clock,
    input  logic                        in_reset,
    input  logic                        in_enable,
    input  logic                        in_seed_load,
    input  logic [LFSR_W-1:0]           in_seed,
    input  logic [NUM_SEG*WEIGHT_W-1:0] in_weights,
    input  logic                        in_req_valid,
    output logic                        out_req_ready,
    output logic                        out_valid,
    input  logic                        in_ready,
    output logic [SEG_W-1:0]            out_segment_number,
    output logic                        out_error,
    output logic                        out_fallback,
    output logic [CNT_W-1:0]            out_draw_count
);

    wrs_state_e state, state_nxt;

    logic [NUM_SEG-1:0][TOT_W-1:0] prefix_c, prefix_r;
    logic [TOT_W-1:0]  total_c, total_r, mask_c, mask_r;
    logic [TOT_W-1:0]  cand, pick;
    logic [NUM_SEG-1:0] hit;
    logic [SEG_W-1:0]  seg_pick, seg_r;
    logic [CNT_W-1:0]  retry_r, draw_cnt_r;
    logic              err_r, fb_r, accept, last_try, accept_req;
    logic [LFSR_W-1:0] lfsr_q;
    logic              unused_lfsr_bits;

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_prefix
        logic [TOT_W-1:0] psum;
        if (i == 0) begin : g_first
            assign psum = TOT_W'(in_weights[WEIGHT_W-1:0]);
        end else begin : g_rest
            assign psum = g_prefix[i-1].psum + TOT_W'(in_weights[i*WEIGHT_W +: WEIGHT_W]);
        end
        assign prefix_c[i] = psum;
    end

    assign total_c = prefix_c[NUM_SEG-1];

    // Smearing total-1 downward gives the next power of two minus one.
    always_comb begin
        mask_c = total_c - TOT_W'(1);
        for (int i = TOT_W - 2; i >= 0; i--) begin
            mask_c[i] = mask_c[i] | mask_c[i+1];
        end
        if (total_c <= TOT_W'(1)) begin
            mask_c = '0;
        end
    end

    wrs_lfsr #(.WIDTH(LFSR_W)) u_lfsr (
        .in_clock     (in_clock),
        .in_reset     (in_reset),
        .in_seed_load (in_seed_load),
        .in_seed      (in_seed),
        .in_step      (in_enable && (state == ST_DRAW)),
        .out_state    (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q;

    assign cand       = lfsr_q[TOT_W-1:0] & mask_r;
    assign accept     = cand < total_r;
    assign pick       = accept ? cand : (cand - total_r);
    assign last_try   = (retry_r + CNT_W'(1)) == CNT_W'(MAX_RETRY);
    assign accept_req = in_req_valid && in_enable;

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_search
        assign hit[i] = pick < prefix_r[i];
    end

    always_comb begin
        seg_pick = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (hit[i]) seg_pick = SEG_W'(i);
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (accept_req) state_nxt = ST_DRAW;
            ST_DRAW:    if (in_enable && (total_r == '0 || accept || last_try)) state_nxt = ST_PRESENT;
            ST_PRESENT: if (in_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            prefix_r   <= '0;
            total_r    <= '0;
            mask_r     <= '0;
            retry_r    <= '0;
            draw_cnt_r <= '0;
            seg_r      <= '0;
            err_r      <= 1'b0;
            fb_r       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept_req) begin
                    prefix_r   <= prefix_c;
                    total_r    <= total_c;
                    mask_r     <= mask_c;
                    retry_r    <= '0;
                    draw_cnt_r <= '0;
                end
                ST_DRAW: if (in_enable) begin
                    if (total_r == '0) begin
                        err_r      <= 1'b1;
                        seg_r      <= '0;
                        draw_cnt_r <= '0;
                    end else begin
                        draw_cnt_r <= draw_cnt_r + CNT_W'(1);
                        if (accept) begin
                            seg_r <= seg_pick;
                        end else if (last_try) begin
                            seg_r <= seg_pick;
                            fb_r  <= 1'b1;
                        end else begin
                            retry_r <= retry_r + CNT_W'(1);
                        end
                    end
                end
                ST_PRESENT: if (in_ready) begin
                    err_r      <= 1'b0;
                    fb_r       <= 1'b0;
                    seg_r      <= '0;
                    draw_cnt_r <= '0;
                end
                default: ;
            endcase
        end
    end

    assign out_req_ready      = (state == ST_IDLE);
    assign out_valid          = (state == ST_PRESENT);
    assign out_segment_number = seg_r;
    assign out_error          = err_r;
    assign out_fallback       = fb_r;
    assign out_draw_count     = draw_cnt_r;

endmodule

// File: tb/tb_weighted_random_select.sv
// tb/tb_weighted_random_select.sv - directed self-checking bench for weighted_random_select
module tb_weighted_random_select;

    localparam logic [31:0] TAPS = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst_n, enable, seed_load;
    logic [31:0] seed, weights;
    logic        rv_a, rv_b, rdy_a, rdy_b;
    logic        rr_a, rr_b, v_a, v_b, e_a, e_b, f_a, f_b;
    logic [1:0]  s_a, s_b, c_b;
    logic [4:0]  c_a;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_lf [2];

    always #5 clk = ~clk;

    weighted_random_select #(.NUM_SEG(4), .WEIGHT_W(8), .LFSR_W(32), .MAX_RETRY(8)) u_dut (
        .in_clock (clk), .in_reset (rst_n), .in_enable (enable), .in_seed_load (seed_load),
        .in_seed (seed), .in_weights (weights), .in_req_valid (rv_a), .out_req_ready (rr_a),
        .out_valid (v_a), .in_ready (rdy_a), .out_segment_number (s_a), .out_error (e_a),
        .out_fallback (f_a), .out_draw_count (c_a)
    );

    weighted_random_select #(.NUM_SEG(4), .WEIGHT_W(8), .LFSR_W(32), .MAX_RETRY(1)) u_fb (
        .in_clock (clk), .in_reset (rst_n), .in_enable (enable), .in_seed_load (seed_load),
        .in_seed (seed), .in_weights (weights), .in_req_valid (rv_b), .out_req_ready (rr_b),
        .out_valid (v_b), .in_ready (rdy_b), .out_segment_number (s_b), .out_error (e_b),
        .out_fallback (f_b), .out_draw_count (c_b)
    );

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int which, output logic rr, output logic v, output logic e,
                          output logic f, output logic [1:0] s, output logic [4:0] c);
        if (which == 0) begin
            rr = rr_a; v = v_a; e = e_a; f = f_a; s = s_a; c = c_a;
        end else begin
            rr = rr_b; v = v_b; e = e_b; f = f_b; s = s_b; c = {3'b000, c_b};
        end
    endtask

    task automatic model(input int which, input logic [31:0] w, output int seg,
                         output int err, output int fb, output int cnt);
        int wt [4];
        int tot, mask, c, acc, maxr;
        bit done, found;
        maxr = (which == 0) ? 8 : 1;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            wt[i] = int'(w[8*i +: 8]);
            tot += wt[i];
        end
        seg = 0; err = 0; fb = 0; cnt = 0; c = 0;
        if (tot == 0) begin
            err = 1;
            m_lf[which] = lfsr_next(m_lf[which]);
            return;
        end
        mask = 1;
        while (mask < tot) mask = mask * 2;
        mask = mask - 1;
        done = 0;
        for (int k = 1; k <= maxr && !done; k++) begin
            c = int'(m_lf[which][9:0]) & mask;
            m_lf[which] = lfsr_next(m_lf[which]);
            cnt = k;
            if (c < tot) begin
                done = 1;
            end else if (k == maxr) begin
                fb = 1;
                c = c - tot;
                done = 1;
            end
        end
        acc = 0; found = 0;
        for (int i = 0; i < 4; i++) begin
            acc += wt[i];
            if (!found && c < acc) begin
                seg = i;
                found = 1;
            end
        end
    endtask

    task automatic load_seed(input logic [31:0] s);
        seed = s; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lf[0] = (s == 0) ? 32'd1 : s;
        m_lf[1] = m_lf[0];
    endtask

    task automatic run_req(input int which, input int stall, input int hold, input bit release_it,
                           output int seg_o, output int fb_o);
        int es, ee, ef, ec, lat;
        logic rr, v, e, f;
        logic [1:0] s;
        logic [4:0] c;
        sample(which, rr, v, e, f, s, c);
        chk("req_ready_idle", 32'(rr), 1);
        if (which == 0) rv_a = 1'b1; else rv_b = 1'b1;
        @(posedge clk); #1;
        if (which == 0) rv_a = 1'b0; else rv_b = 1'b0;
        model(which, weights, es, ee, ef, ec);
        if (stall > 0) begin
            enable = 1'b0;
            weights = $urandom;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                sample(which, rr, v, e, f, s, c);
                chk("stall_valid", 32'(v), 0);
                chk("stall_draw_count", 32'(c), 0);
            end
            enable = 1'b1;
        end
        lat = 0;
        sample(which, rr, v, e, f, s, c);
        while (!v && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            sample(which, rr, v, e, f, s, c);
        end
        chk("valid", 32'(v), 1);
        chk("latency", lat, (ee != 0) ? 1 : ec);
        chk("segment", 32'(s), es);
        chk("error", 32'(e), ee);
        chk("fallback", 32'(f), ef);
        chk("draw_count", 32'(c), ec);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            sample(which, rr, v, e, f, s, c);
            chk("hold_valid", 32'(v), 1);
            chk("hold_req_ready", 32'(rr), 0);
            chk("hold_segment", 32'(s), es);
            chk("hold_flags", {30'd0, e, f}, (ee * 2) + ef);
            chk("hold_draw_count", 32'(c), ec);
        end
        seg_o = int'(s);
        fb_o  = int'(f);
        if (release_it) begin
            if (which == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
            @(posedge clk); #1;
            rdy_a = 1'b0; rdy_b = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seg, fb, nfb;
        int hist [4];
        int rec [20];
        int expc [3];

        rst_n = 1'b0; enable = 1'b0; seed_load = 1'b0; seed = '0; weights = '0;
        rv_a = 1'b0; rv_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        m_lf[0] = 32'd1; m_lf[1] = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(v_a), 0);
        chk("reset_segment", 32'(s_a), 0);
        chk("reset_flags", {30'd0, e_a, f_a}, 0);
        chk("reset_draw_count", 32'(c_a), 0);
        chk("reset_fb_valid", 32'(v_b), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_req_ready_a", 32'(rr_a), 1);
        chk("release_req_ready_b", 32'(rr_b), 1);
        enable = 1'b1;

        // All-zero weights: error result two cycles after the request.
        weights = 32'h0;
        run_req(0, 0, 0, 1, seg, fb);

        // Backpressure for 10 cycles.
        weights = 32'h00_03_00_01;
        run_req(0, 0, 10, 1, seg, fb);

        // Stall right after acceptance, with weights disturbed meanwhile.
        weights = 32'h01_02_03_04;
        run_req(0, 5, 0, 1, seg, fb);

        // Distribution {2,4,2,0} from seed 1.
        load_seed(32'd1);
        weights = 32'h00_02_04_02;
        for (int i = 0; i < 4; i++) hist[i] = 0;
        for (int n = 0; n < 4000; n++) begin
            run_req(0, 0, 0, 1, seg, fb);
            hist[seg]++;
        end
        expc[0] = 1000; expc[1] = 2000; expc[2] = 1000;
        $display("distribution: %0d %0d %0d %0d", hist[0], hist[1], hist[2], hist[3]);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dist_seg%0d_in_range", i),
                32'((hist[i] >= expc[i] - 120) && (hist[i] <= expc[i] + 120)), 1);
        end
        chk("dist_seg3_never", hist[3], 0);

        // Single non-zero weight with a one-draw budget on the second instance.
        weights = 32'h05_00_00_00;
        nfb = 0;
        for (int n = 0; n < 500; n++) begin
            run_req(1, 0, 0, 1, seg, fb);
            chk("single_weight_segment", seg, 3);
            nfb += fb;
        end
        chk("fallback_seen", 32'(nfb > 0 && nfb < 500), 1);

        // Reseed with 0xACE1 twice gives the same 20 results.
        weights = 32'h04_03_02_01;
        load_seed(32'h0000ACE1);
        for (int n = 0; n < 20; n++) begin
            run_req(0, 0, 0, 1, seg, fb);
            rec[n] = seg;
        end
        load_seed(32'h0000ACE1);
        for (int n = 0; n < 20; n++) begin
            run_req(0, 0, 0, 1, seg, fb);
            chk("reseed_repeat", seg, rec[n]);
        end

        // Seed 0 behaves as seed 1.
        load_seed(32'd0);
        for (int n = 0; n < 10; n++) begin
            run_req(0, 0, 0, 1, seg, fb);
            rec[n] = seg;
        end
        load_seed(32'd1);
        for (int n = 0; n < 10; n++) begin
            run_req(0, 0, 0, 1, seg, fb);
            chk("seed0_equals_seed1", seg, rec[n]);
        end

        // Reset with one instance in PRESENT and the other frozen in DRAW.
        weights = 32'h00_00_00_07;
        run_req(1, 0, 0, 0, seg, fb);
        rv_a = 1'b1;
        @(posedge clk); #1;
        rv_a = 1'b0;
        enable = 1'b0;
        chk("pre_reset_draw_valid", 32'(v_a), 0);
        chk("pre_reset_present_valid", 32'(v_b), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid_a", 32'(v_a), 0);
        chk("async_reset_valid_b", 32'(v_b), 0);
        chk("async_reset_req_ready_a", 32'(rr_a), 1);
        chk("async_reset_req_ready_b", 32'(rr_b), 1);
        chk("async_reset_draw_count", 32'(c_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        enable = 1'b1;
        m_lf[0] = 32'd1; m_lf[1] = 32'd1;
        weights = 32'h01_02_03_04;
        for (int n = 0; n < 4; n++) run_req(0, 0, 0, 1, seg, fb);
        weights = 32'h05_00_00_00;
        for (int n = 0; n < 4; n++) run_req(1, 0, 0, 1, seg, fb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weighted_random_select.md
Name: weighted_random_select

Overview:
- Parametrised successor of the 4-way RandomChoose weighted segment picker.
- Draws one segment index out of NUM_SEG per request, with probability weight[i]/sum(weights).
- Uses an internal LFSR plus rejection sampling, so the distribution is unbiased.
- Sits between the traffic/address-generation logic and the segment scheduler of the memory-controller configurator; adds a valid/ready handshake, reseeding, stall, zero-weight error and retry-bounded fallback.

Parameters:
- NUM_SEG, 4: number of selectable segments (2..16).
- WEIGHT_W, 8: bits per weight.
- LFSR_W, 32: LFSR width; legal values are 16, 24, 32. Must be ≥ TOT_W.
- MAX_RETRY, 8: rejected draws allowed before the fallback pick (≥1).
- Derived: SEG_W = max(1, clog2(NUM_SEG)); TOT_W = WEIGHT_W + clog2(NUM_SEG).

Ports:
- in_clock  in  1  sole clock, rising edge.
- in_reset  in  1  asynchronous, active-low reset.
- in_enable  in  1  global run enable; low freezes DRAW and the LFSR.
- in_seed_load  in  1  load in_seed into the LFSR this cycle.
- in_seed  in  LFSR_W  seed value.
- in_weights  in  NUM_SEG*WEIGHT_W  packed weights; segment i occupies [i*WEIGHT_W +: WEIGHT_W].
- in_req_valid  in  1  selection request.
- out_req_ready  out  1  request accepted when high together with in_req_valid.
- out_valid  out  1  result available.
- in_ready  in  1  consumer accepts the result.
- out_segment_number  out  SEG_W  chosen segment.
- out_error  out  1  all weights were zero; result is meaningless.
- out_fallback  out  1  result came from the fallback path.
- out_draw_count  out  clog2(MAX_RETRY+1)+1  draws consumed for this result.

Behaviour:
- Reset (in_reset=0, asynchronous): state=IDLE; LFSR=1; all outputs and internal registers 0, except out_req_ready, which is 1 after reset release.
- FSM states: IDLE, DRAW, PRESENT. out_req_ready = (state==IDLE). out_valid = (state==PRESENT).
- IDLE:
  - On in_req_valid & in_enable (cycle T): latch all weights.
  - Register total (TOT_W bits, no overflow possible).
  - Register inclusive prefix sums P[i].
  - Register mask = 2^ceil(log2(total)) - 1, with mask=0 when total≤1.
  - Clear retry and draw counters. Go to DRAW.
- DRAW, evaluated only when in_enable=1:
  - If total==0: PRESENT with out_error=1, segment 0, draw_count 0.
  - Else c = LFSR[TOT_W-1:0] & mask; draw_count++.
  - If c < total: segment = smallest i with c < P[i] (zero-weight segments are never chosen); go to PRESENT.
  - Else if retry+1 == MAX_RETRY: segment is chosen from c-total (always < total, since mask+1 < 2*total); out_fallback=1; go to PRESENT.
  - Else retry++, stay in DRAW.
  - The LFSR steps once per enabled DRAW cycle only.
- Latency: minimum 2 cycles (out_valid at T+2), maximum MAX_RETRY+1 cycles with in_enable held high.
- PRESENT:
  - Segment and all flags hold stable until in_ready=1.
  - On that edge go to IDLE and clear the flags.
  - in_ready is ignored in other states. in_enable does not gate PRESENT.
- LFSR:
  - Galois, maximal-length taps from the package.
  - in_seed_load has priority over stepping in any state.
  - A zero seed is replaced by 1.
  - The DRAW compare always uses the current register value, so a load takes effect on the next compare.
- in_enable=0: IDLE does not accept requests; DRAW and LFSR freeze; PRESENT unaffected.
- Weights change while busy: no effect until the next acceptance.
- Reset mid-DRAW or mid-PRESENT: immediate abort. out_valid drops asynchronously and the result is lost.

Decomposition:
- Package wrs_pkg holds:
  - LFSR tap constants for widths 16/24/32 and a tap-lookup function.
  - State encoding constants.
  - A clog2 helper.
- Sub-module wrs_lfsr (width parameter; seed load, step enable, zero-seed guard).
- Prefix-sum and the index search stay in the top level as generate loops.

Test Plan:
- Distribution: weights {2,4,2,0}, seed 1, 4000 back-to-back requests with in_ready=1 → segment counts within ±3% of 1000/2000/1000/0; segment 3 never seen; out_error=0.
- Zero weights: all weights 0, request at T → out_valid=1 at T+2, out_error=1, segment 0, out_draw_count=0.
- Single weight with fallback forced:
  - Stimulus: weights {0,0,0,5}, MAX_RETRY=1, 500 requests.
  - Required: always segment 3; out_fallback asserted only when c∈{5,6,7}; result compared against a bench LFSR model.
- Backpressure and stall:
  - Hold in_ready=0 for 10 cycles in PRESENT → segment and flags stable, out_req_ready=0.
  - Drop in_enable mid-DRAW for 5 cycles → LFSR and draw_count frozen, result identical to an unstalled model.
- Reseed:
  - Load seed 0xACE1, record 20 results, reload 0xACE1 → identical 20 results.
  - Seed 0 gives the same sequence as seed 1.
- Reset mid-DRAW: assert in_reset=0 while in DRAW → out_valid=0 immediately; after release out_req_ready=1 and the LFSR restarts from 1.
